ps2_key_decoder: RTL and testbench

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and turns them into a held-key scancode `result[7:0]`. This is the stage directly upstream of the player movement controller. `result` holds the make code of the most recently pressed, still-held key (set-2 codes, e.g. 0x1C 'A', 0x23 'D') and is 0x00 when no tracked key is held. The controller samples `result` once per frame tick, so `result` is a level, not a pulse.

---
 rtl/ps2_key_decoder.sv | 188 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw pins, frames bytes and tracks the held make code.
// Optional build macro PS2_PARITY_CHECK_EN discards frames whose parity is not odd.
//
// State    | Meaning
// ---------|------------------------------------------------------------
// S_IDLE   | waiting for a start bit (data=0 on a sample event)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking the stop bit, then releasing the byte or an error
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 40_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] result,
    output logic       key_strobe,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    FILT_TC = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_TC   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          fclk_q, fall_q, samp_dat_q;
    logic [7:0]    filt_cnt_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [TW-1:0] to_cnt_q;
    logic          byte_valid_q, frame_err_q;
    logic [7:0]    byte_q;
    logic          brk_q, ext_q;
    logic [7:0]    result_q;
    logic          key_strobe_q;
    logic          frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // fclk only follows after FILTER_LEN consecutive samples disagreeing with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fclk_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            samp_dat_q <= 1'b1;
        end else if (clk_s2_q == fclk_q) begin
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else if (filt_cnt_q == FILT_TC) begin
            fclk_q     <= clk_s2_q;
            filt_cnt_q <= '0;
            fall_q     <= fclk_q;
            samp_dat_q <= dat_s2_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + 8'd1;
            fall_q     <= 1'b0;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (fall_q && state_q == S_PARITY) begin
            par_q <= samp_dat_q;
        end
    end

    assign frame_ok = samp_dat_q & (^{shift_q, par_q});
`else
    assign frame_ok = samp_dat_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q == S_IDLE || fall_q) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (fall_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (!samp_dat_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {samp_dat_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (frame_ok) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE && to_cnt_q == TO_TC) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    // F0 marks a release, E0 marks an untracked extended key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            result_q     <= '0;
            key_strobe_q <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            if (byte_valid_q) begin
                if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (ext_q) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else if (brk_q) begin
                    brk_q <= 1'b0;
                    if (byte_q == result_q) begin
                        result_q <= '0;
                    end
                end else if (byte_q != result_q) begin
                    result_q     <= byte_q;
                    key_strobe_q <= (byte_q != 8'h00);
                end
            end
        end
    end

    assign result     = result_q;
    assign key_strobe = key_strobe_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random key traffic vs a key-tracking model.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TOUT = 400;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] result;
    logic       key_strobe;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;
    int n_ferr = 0;
    int n_overlap = 0;

    // reference model state
    logic [7:0] m_res = 8'h00;
    bit         m_brk = 0;
    bit         m_ext = 0;
    int         m_strobe = 0;
    int         m_ferr = 0;
`ifdef PS2_PARITY_CHECK_EN
    bit         par_en = 1;
`else
    bit         par_en = 0;
`endif

    ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .result(result), .key_strobe(key_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_strobe) n_strobe++;
        if (frame_err) n_ferr++;
        if (key_strobe && frame_err) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (m_ext) begin m_ext = 0; m_brk = 0; end
        else if (m_brk) begin
            if (b == m_res) m_res = 8'h00;
            m_brk = 0;
        end else if (b != m_res) begin
            m_res = b;
            if (b != 8'h00) m_strobe++;
        end
    endfunction

    // Drives nbits of an 11-bit frame; data changes while the clock is high.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cycles(HALF);
            ps2_clk = 1'b0;
            cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        @(negedge clk);
        check({tag, ".result"}, 32'(result), 32'(m_res));
        check({tag, ".strobes"}, n_strobe, m_strobe);
        check({tag, ".errs"}, n_ferr, m_ferr);
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_frame(b, bad_par, bad_stop, 11);
        if (bad_stop || (bad_par && par_en)) m_ferr++;
        else model_byte(b);
    endtask

    task automatic xfer_chk(input string tag, input logic [7:0] b);
        xfer(b, 0, 0);
        cycles(10);
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] pool [7] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'hF0, 8'hE0, 8'h74};
        cycles(5);
        @(negedge clk);
        check("rst.result", 32'(result), 0);
        check("rst.strobe", 32'(key_strobe), 0);
        check("rst.ferr", 32'(frame_err), 0);
        rst_n = 1'b1;
        cycles(5);

        xfer_chk("press23", 8'h23);
        check("press23.one", n_strobe, 1);
        repeat (3) xfer_chk("repeat23", 8'h23);
        check("repeat23.val", 32'(result), 32'h23);
        xfer(8'hF0, 0, 0); xfer_chk("rel23", 8'h23);
        check("rel23.zero", 32'(result), 0);
        xfer(8'hF0, 0, 0); xfer_chk("rel1C_none", 8'h1C);

        xfer_chk("press23b", 8'h23);
        xfer_chk("press1C", 8'h1C);
        check("press1C.val", 32'(result), 32'h1C);
        xfer(8'hF0, 0, 0); xfer_chk("rel_other", 8'h23);
        check("rel_other.val", 32'(result), 32'h1C);

        xfer(8'hE0, 0, 0); xfer_chk("ext_make", 8'h74);
        xfer(8'hE0, 0, 0); xfer(8'hF0, 0, 0); xfer_chk("ext_brk", 8'h74);
        check("ext.val", 32'(result), 32'h1C);

        xfer(8'h23, 1, 0); cycles(10); compare_all("badpar");
        xfer(8'h1B, 0, 1); cycles(10); compare_all("badstop");

        send_frame(8'h35, 0, 0, 5);
        cycles(2 * TOUT);
        m_ferr++;
        compare_all("timeout");
        xfer_chk("after_to", 8'h1C);

        for (int i = 0; i < 80; i++) begin
            logic [7:0] b;
            int r;
            b = pool[$urandom_range(0, 6)];
            r = $urandom_range(0, 19);
            xfer(b, r == 0, r == 1);
            if ($urandom_range(0, 1) == 0) begin
                cycles(10);
                compare_all($sformatf("rnd%0d", i));
            end
        end

        xfer(8'hF0, 0, 0); xfer(m_res, 0, 0); xfer(8'h1D, 0, 0);
        cycles(10);
        compare_all("b2b");

        xfer(8'hF0, 0, 0);
        send_frame(8'h42, 0, 0, 4);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        m_res = 8'h00; m_brk = 0; m_ext = 0;
        cycles(3);
        @(negedge clk);
        check("midrst.result", 32'(result), 0);
        check("midrst.strobe", 32'(key_strobe), 0);
        check("midrst.ferr", 32'(frame_err), 0);
        rst_n = 1'b1;
        cycles(2 * TOUT);
        compare_all("midrst.quiet");
        xfer_chk("post_rst", 8'h23);
        check("post_rst.val", 32'(result), 32'h23);

        check("overlap", n_overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
